dma_reg_arbiter: RTL
====================

Name: dma_reg_arbiter

Overview:
- Round-robin arbiter sharing the single DMA register bus (wr_en/rd_en/addr/wdata/rdata) among NUM_REQ requesters, e.g. CPU bridge, descriptor fetcher and status poller.
- Accepts at most one request per cycle via a per-requester valid/ready handshake and drives registered bus strobes.
- Tracks in-flight reads by requester ID so fixed-latency rdata returns to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from the rd_en cycle to the rdata-valid cycle on the bus (1..4).

Ports:
- clk  input  1  bus clock.
- rst_n  input  1  reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  input  NUM_REQ*DW  packed write data.
- req_ready  output  NUM_REQ  one-hot accept, combinational.
- rsp_valid  output  NUM_REQ  one-hot read-data-valid pulse.
- rsp_rdata  output  DW  read data, shared by all requesters and qualified by rsp_valid.
- wr_en  output  1  bus write strobe.
- rd_en  output  1  bus read strobe.
- addr  output  AW  bus address.
- wdata  output  DW  bus write data.
- rdata  input  DW  bus read data.

Behaviour:
- Reset and clocking:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - During reset all outputs are 0: req_ready, rsp_valid, rsp_rdata, wr_en, rd_en, addr, wdata.
  - The rr pointer resets to 0 and all in-flight read tags are cleared.
- Arbitration:
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins. req_ready[win]=1 in the same cycle; all other ready bits are 0.
  - With no valid request, req_ready is 0 and ptr holds.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid, we, addr and wdata stable until accepted.
  - A losing requester keeps valid asserted and is not dropped.
- Pointer:
  - On a grant to index g, ptr <= (g+1) mod NUM_REQ.
  - Result: every continuously requesting requester is served within NUM_REQ cycles.
- Bus issue (latency 1):
  - A grant in cycle t drives one of the following in cycle t+1, with all fields registered:
    - write: wr_en=1, addr, wdata;
    - read: rd_en=1, addr.
  - wr_en and rd_en are never both 1.
  - In cycles with no grant, both strobes are 0 and addr/wdata hold their last values.
- Read return:
  - A tag pipeline of depth RD_LAT+1 carries {valid, id}.
  - Bus rdata is sampled RD_LAT cycles after the rd_en cycle.
  - rsp_valid[id] and rsp_rdata are registered, appearing in cycle t+2+RD_LAT for a grant at cycle t.
  - rsp_rdata holds its last value otherwise.
- Writes produce no response.
- Back-to-back operation:
  - One grant per cycle, sustained.
  - Reads from different requesters may be in flight simultaneously. Responses return in issue order, one per cycle, with no collisions.
- Mid-operation reset: in-flight reads are discarded and no rsp_valid follows reset deassertion.
- Width rules:
  - The pointer and ID are $clog2(NUM_REQ) bits.
  - Wrap is computed explicitly; power-of-two NUM_REQ is not required.

Decomposition:
- Package dma_arb_pkg holds:
  - typedef of the tag struct {logic vld; logic [IDW-1:0] id};
  - function rr_pick(req, ptr), returning the one-hot winner;
  - constant MAX_REQ=8.
- One sub-module, dma_rr_arbiter:
  - pure round-robin grant logic with pointer register;
  - reused by future descriptor-queue schedulers.
- The top level holds the bus registers and the read-tag pipeline.

Test Plan:
1. Reset: drive rst_n=0 mid-read (rd_en issued, rdata pending) -> all outputs 0 immediately. No rsp_valid after release. First grant goes to requester 0 when all request.
2. Single write: req 2 writes addr=0x10, wdata=0xDEADBEEF at cycle t -> req_ready=4'b0100 at t. At t+1: wr_en=1, addr=0x10, wdata=0xDEADBEEF. No rsp_valid.
3. Single read, RD_LAT=1: req 1 reads 0x08 at t and the model returns 0x12345678 at t+2 -> rd_en at t+1; rsp_valid=4'b0010 and rsp_rdata=0x12345678 at t+3.
4. Fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Exactly one strobe per cycle from t+1.
5. Interleaved reads: req 3 then req 0 read on consecutive cycles, with model data 0xAAAA0003 and 0xBBBB0000 -> rsp_valid 4'b1000 then 4'b0001 on consecutive cycles with matching data. Repeat with RD_LAT=3.
6. Pointer wrap and hold: only req 3 valid, then only req 0 -> ptr 3 → 0 → 1. Hold req 2 valid while req 1 is granted repeatedly -> req 2 is granted within 4 cycles and its fields stay unchanged.

Source files
------------

// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_arb_pkg
// Description : Shared types and helpers for the DMA register-bus arbiter:
//               read-tag struct and the round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

  // Largest requester count any instance may use; sizes the shared types.
  localparam int MAX_REQ = 8;
  localparam int IDW     = $clog2(MAX_REQ);

  // One stage of the in-flight read tracker: occupied flag plus issuer id.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } rd_tag_t;

  // Returns a one-hot winner: first set bit of req at or after ptr, wrapping
  // at num (not at MAX_REQ), so non-power-of-two counts rotate correctly.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDW-1:0]     ptr,
    input int                 num
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num) idx = idx - num;
      if ((k < num) && !found && req[idx[IDW-1:0]]) begin
        gnt[idx[IDW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_rr_arbiter
// Description : Round-robin grant logic with rotating priority pointer.
//               Grant is combinational; the pointer advances past each winner.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_vld,
  output logic [PW-1:0]      o_gnt_id
);

  logic [PW-1:0]      r_ptr;
  logic [MAX_REQ-1:0] w_pick;
  logic               w_unused_pick;
  logic [PW-1:0]      w_id;

  // Pick the winner; grants are forced low while reset is held.
  always_comb begin
    w_pick        = rr_pick(MAX_REQ'(i_req), IDW'(r_ptr), NUM_REQ);
    w_unused_pick = ^w_pick;
    o_gnt         = rst_n ? w_pick[NUM_REQ-1:0] : '0;
    o_gnt_vld     = |o_gnt;
  end

  // Encode the one-hot grant into the winner's index.
  always_comb begin
    w_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_gnt[i]) w_id = PW'(i);
    end
    o_gnt_id = w_id;
  end

  // Move priority to the requester just after the winner; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (w_id == PW'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_reg_arbiter
// Description : Shares one DMA register bus among NUM_REQ requesters.
//               Registered bus strobes one cycle after grant; fixed-latency
//               read data is steered back to its issuer via a tag pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_reg_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_we,
  input  logic [NUM_REQ*AW-1:0] i_req_addr,
  input  logic [NUM_REQ*DW-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_wr_en,
  output logic                  o_rd_en,
  output logic [AW-1:0]         o_addr,
  output logic [DW-1:0]         o_wdata,
  input  logic [DW-1:0]         i_rdata
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt_id;
  logic               w_sel_we;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_wdata;

  logic               r_wr_en;
  logic               r_rd_en;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  rd_tag_t            r_tag [RD_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DW-1:0]      r_rsp_rdata;

  dma_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  // Select the winning requester's command fields (one-hot mux).
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_we    = i_req_we[i];
        w_sel_addr  = i_req_addr[i*AW +: AW];
        w_sel_wdata = i_req_wdata[i*DW +: DW];
      end
    end
  end

  // Bus command registers; addr/wdata hold when idle, wdata only moves on writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt_vld) begin
      r_wr_en <= w_sel_we;
      r_rd_en <= ~w_sel_we;
      r_addr  <= w_sel_addr;
      if (w_sel_we) r_wdata <= w_sel_wdata;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 lines up with rd_en, stage RD_LAT with bus rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].vld <= w_gnt_vld & ~w_sel_we;
      r_tag[0].id  <= IDW'(w_gnt_id);
      for (int k = 1; k <= RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Capture returning read data and pulse the issuer's response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= r_tag[RD_LAT].vld && (r_tag[RD_LAT].id == IDW'(i));
      end
      if (r_tag[RD_LAT].vld) r_rsp_rdata <= i_rdata;
    end
  end

  assign o_req_ready = w_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_wr_en     = r_wr_en;
  assign o_rd_en     = r_rd_en;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;

endmodule
`default_nettype wire
